mem_axil_bridge: RTL and testbench

MEM_AXIL_BRIDGE -- requirements
Module: mem_axil_bridge

---
 rtl/mem_axil_bridge.sv | 270 +++++++++++++++++++++++++++
 tb/tb_mem_axil_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axil_bridge.sv
// -----------------------------------------------------------------------------
// mem_axil_bridge
//
// Purpose:
//   Bridges a simple native memory request interface (valid/ready, wstrb==0
//   means read) onto an AXI4-Lite master port. One transaction is in flight
//   at a time. Every AXI phase is guarded by a wait counter: if a phase stalls
//   for TIMEOUT cycles, the bridge drops its valids/readies and completes the
//   native request with bus_err. On an aborted read, mem_rdata is all ones.
//
// Parameters:
//   TIMEOUT     cycles a single AXI phase may wait before it is aborted (1..255)
//   PROT_DATA   AxPROT value driven for data accesses
//   PROT_INSTR  ARPROT value driven for instruction fetches
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   mem_valid_i / mem_instr_i   native request strobe / request is a fetch
//   mem_addr_i                  byte address
//   mem_wdata_i / mem_wstrb_i   write data / byte enables (0 = read)
//   mem_ready_o                 one-cycle completion pulse
//   mem_rdata_o                 read data, valid with mem_ready_o
//   m_aw*  / m_w* / m_b*        AXI4-Lite write address / data / response
//   m_ar*  / m_r*               AXI4-Lite read address / data
//   bus_err_o                   one-cycle pulse on error response or timeout
// -----------------------------------------------------------------------------
module mem_axil_bridge #(
    parameter int         TIMEOUT    = 255,
    parameter logic [2:0] PROT_DATA  = 3'b000,
    parameter logic [2:0] PROT_INSTR = 3'b100
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,

    output logic        m_awvalid_o,
    output logic [31:0] m_awaddr_o,
    output logic [2:0]  m_awprot_o,
    input  logic        m_awready_i,

    output logic        m_wvalid_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o,
    input  logic        m_wready_i,

    input  logic        m_bvalid_i,
    input  logic [1:0]  m_bresp_i,
    output logic        m_bready_o,

    output logic        m_arvalid_o,
    output logic [31:0] m_araddr_o,
    output logic [2:0]  m_arprot_o,
    input  logic        m_arready_i,

    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    output logic        m_rready_o,

    output logic        bus_err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  wait_q;
    logic [7:0]  wait_d;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        timeout;
    logic        aw_pending;
    logic        w_pending;

    // Counter value if the current state is held for another cycle. The abort
    // fires on the cycle whose increment would reach TIMEOUT, so a phase waits
    // for exactly TIMEOUT cycles before it is dropped.
    assign wait_d  = wait_q + 8'd1;
    assign timeout = (wait_d == WAIT_LIMIT);

    // A write channel is still outstanding if its valid is up and the slave
    // does not accept it in this cycle.
    assign aw_pending = awvalid_q && !m_awready_i;
    assign w_pending  = wvalid_q && !m_wready_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            instr_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            // Completion and error are single-cycle pulses.
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    wait_q <= 8'd0;
                    if (mem_valid_i) begin
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        wstrb_q <= mem_wstrb_i;
                        instr_q <= mem_instr_i;
                        if (mem_wstrb_i != 4'd0) begin
                            state_q   <= WADDR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                WADDR: begin
                    // Address and data may be accepted in different cycles;
                    // each valid drops on its own handshake.
                    if (m_awready_i) awvalid_q <= 1'b0;
                    if (m_wready_i)  wvalid_q  <= 1'b0;

                    if (!aw_pending && !w_pending) begin
                        state_q  <= WRESP;
                        bready_q <= 1'b1;
                        wait_q   <= 8'd0;
                    end else if (timeout) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                        wait_q    <= 8'd0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                WRESP: begin
                    if (m_bvalid_i) begin
                        bready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        err_q    <= (m_bresp_i != 2'b00);
                        state_q  <= DONE;
                        wait_q   <= 8'd0;
                    end else if (timeout) begin
                        bready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= DONE;
                        wait_q   <= 8'd0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                RADDR: begin
                    if (m_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                        wait_q    <= 8'd0;
                    end else if (timeout) begin
                        arvalid_q <= 1'b0;
                        rdata_q   <= 32'hFFFF_FFFF;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                        wait_q    <= 8'd0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                RDATA: begin
                    if (m_rvalid_i) begin
                        // Error responses still pass their data through.
                        rready_q <= 1'b0;
                        rdata_q  <= m_rdata_i;
                        ready_q  <= 1'b1;
                        err_q    <= (m_rresp_i != 2'b00);
                        state_q  <= DONE;
                        wait_q   <= 8'd0;
                    end else if (timeout) begin
                        rready_q <= 1'b0;
                        rdata_q  <= 32'hFFFF_FFFF;
                        ready_q  <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= DONE;
                        wait_q   <= 8'd0;
                    end else begin
                        wait_q <= wait_d;
                    end
                end

                DONE: begin
                    // The requester still shows valid in this cycle because it
                    // only just saw ready; do not start a second transaction.
                    state_q <= IDLE;
                    wait_q  <= 8'd0;
                end

                default: begin
                    state_q <= IDLE;
                    wait_q  <= 8'd0;
                end
            endcase
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign bus_err_o   = err_q;

    // Payload registers only change in IDLE, so they are stable while any
    // valid is raised.
    assign m_awvalid_o = awvalid_q;
    assign m_awaddr_o  = addr_q;
    assign m_awprot_o  = PROT_DATA;

    assign m_wvalid_o  = wvalid_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;

    assign m_bready_o  = bready_q;

    assign m_arvalid_o = arvalid_q;
    assign m_araddr_o  = addr_q;
    assign m_arprot_o  = instr_q ? PROT_INSTR : PROT_DATA;

    assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_mem_axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_mem_axil_bridge
//
// Bench for mem_axil_bridge with default parameters. An AXI4-Lite slave with
// per-channel response delays is emulated cycle by cycle; transaction
// expectations come from a table of hand-worked cases and, for random traffic,
// from a delay-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mem_axil_bridge;

    localparam int T = 255;

    logic        clk = 1'b0;
    logic        resetn;

    logic        mem_valid_i;
    logic        mem_instr_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic        m_awvalid_o;
    logic [31:0] m_awaddr_o;
    logic [2:0]  m_awprot_o;
    logic        m_awready_i;
    logic        m_wvalid_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_wready_i;
    logic        m_bvalid_i;
    logic [1:0]  m_bresp_i;
    logic        m_bready_o;
    logic        m_arvalid_o;
    logic [31:0] m_araddr_o;
    logic [2:0]  m_arprot_o;
    logic        m_arready_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rready_o;
    logic        bus_err_o;

    always #5 clk = ~clk;

    mem_axil_bridge dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_valid_i (mem_valid_i),
        .mem_instr_i (mem_instr_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .m_awvalid_o (m_awvalid_o),
        .m_awaddr_o  (m_awaddr_o),
        .m_awprot_o  (m_awprot_o),
        .m_awready_i (m_awready_i),
        .m_wvalid_o  (m_wvalid_o),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_wready_i  (m_wready_i),
        .m_bvalid_i  (m_bvalid_i),
        .m_bresp_i   (m_bresp_i),
        .m_bready_o  (m_bready_o),
        .m_arvalid_o (m_arvalid_o),
        .m_araddr_o  (m_araddr_o),
        .m_arprot_o  (m_arprot_o),
        .m_arready_i (m_arready_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rdata_i   (m_rdata_i),
        .m_rresp_i   (m_rresp_i),
        .m_rready_o  (m_rready_o),
        .bus_err_o   (bus_err_o)
    );

    // Transaction record. Reads use d1 = AR delay, d2 = R delay; writes use
    // d1 = AW delay, d2 = W delay, d3 = B delay. A delay >= T never answers.
    typedef struct {
        bit          is_w;
        bit          instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d1;
        int          d2;
        int          d3;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          drop_early;
        int          lat;
        bit          err;
        logic [31:0] rdata_exp;
    } vec_t;

    typedef struct {
        int          lat;
        int          err;
        logic [31:0] rdata;
        int          aw_hi, w_hi, b_hi, ar_hi, r_hi;
        int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    } exp_t;

    int total = 0;
    int bad   = 0;

    // Slave configuration and expected payload of the current transaction.
    int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [2:0]  exp_arprot;

    // Observations; *_cnt = cycles the master held valid/ready, *_hs = handshakes.
    int          cyc, ready_cnt, ready_at, err_cnt, err_at, payload_bad;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] rdata_seen;

    vec_t tbl [11];
    vec_t v;
    exp_t e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; ready_cnt = 0; ready_at = -1; err_cnt = 0; err_at = -1;
        payload_bad = 0; rdata_seen = 32'd0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    endtask

    // One clock: observe the DUT at the falling edge, then set slave inputs
    // for the next rising edge. A channel answers once the master has been
    // waiting on it for the configured number of cycles.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (mem_ready_o) begin
            if (ready_cnt == 0) begin
                ready_at   = cyc;
                rdata_seen = mem_rdata_o;
            end
            ready_cnt++;
        end
        if (bus_err_o) begin
            err_cnt++;
            err_at = cyc;
        end
        if (m_awvalid_o && (m_awaddr_o != exp_addr || m_awprot_o != 3'b000)) payload_bad++;
        if (m_wvalid_o && (m_wdata_o != exp_wdata || m_wstrb_o != exp_wstrb)) payload_bad++;
        if (m_arvalid_o && (m_araddr_o != exp_addr || m_arprot_o != exp_arprot)) payload_bad++;

        m_awready_i = m_awvalid_o && (aw_cnt >= cfg_aw);
        if (m_awvalid_o) begin
            if (m_awready_i) aw_hs++;
            aw_cnt++;
        end
        m_wready_i = m_wvalid_o && (w_cnt >= cfg_w);
        if (m_wvalid_o) begin
            if (m_wready_i) w_hs++;
            w_cnt++;
        end
        m_bvalid_i = m_bready_o && (b_cnt >= cfg_b);
        m_bresp_i  = m_bvalid_i ? cfg_resp : 2'b00;
        if (m_bready_o) begin
            if (m_bvalid_i) b_hs++;
            b_cnt++;
        end
        m_arready_i = m_arvalid_o && (ar_cnt >= cfg_ar);
        if (m_arvalid_o) begin
            if (m_arready_i) ar_hs++;
            ar_cnt++;
        end
        m_rvalid_i = m_rready_o && (r_cnt >= cfg_r);
        m_rdata_i  = m_rvalid_i ? cfg_rdata : 32'd0;
        m_rresp_i  = m_rvalid_i ? cfg_resp : 2'b00;
        if (m_rready_o) begin
            if (m_rvalid_i) r_hs++;
            r_cnt++;
        end
    endtask

    // Reference: each phase lasts (delay + 1) cycles if the delay is below T,
    // otherwise it is cut off after T cycles and the request ends in error.
    // One cycle to leave IDLE plus one DONE cycle make up the rest.
    function automatic exp_t model(input vec_t t);
        exp_t r;
        int   m;
        r = '{default: 0};
        if (!t.is_w) begin
            if (t.d1 >= T) begin
                r.lat = T + 1; r.err = 1; r.rdata = 32'hFFFF_FFFF; r.ar_hi = T;
            end else begin
                r.ar_hi = t.d1 + 1; r.ar_hs = 1;
                if (t.d2 >= T) begin
                    r.lat = t.d1 + 1 + T + 1; r.err = 1; r.rdata = 32'hFFFF_FFFF; r.r_hi = T;
                end else begin
                    r.lat = t.d1 + t.d2 + 3; r.err = (t.resp != 2'b00) ? 1 : 0;
                    r.rdata = t.rdata; r.r_hi = t.d2 + 1; r.r_hs = 1;
                end
            end
        end else begin
            m = (t.d1 > t.d2) ? t.d1 : t.d2;
            r.aw_hi = (t.d1 < T) ? t.d1 + 1 : T;
            r.w_hi  = (t.d2 < T) ? t.d2 + 1 : T;
            r.aw_hs = (t.d1 < T) ? 1 : 0;
            r.w_hs  = (t.d2 < T) ? 1 : 0;
            if (m >= T) begin
                r.lat = T + 1; r.err = 1;
            end else if (t.d3 >= T) begin
                r.lat = m + 1 + T + 1; r.err = 1; r.b_hi = T;
            end else begin
                r.lat = m + t.d3 + 3; r.err = (t.resp != 2'b00) ? 1 : 0;
                r.b_hi = t.d3 + 1; r.b_hs = 1;
            end
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t t, input exp_t x, input string tag);
        cfg_aw = t.is_w ? t.d1 : 0;
        cfg_w  = t.is_w ? t.d2 : 0;
        cfg_b  = t.is_w ? t.d3 : 0;
        cfg_ar = t.is_w ? 0 : t.d1;
        cfg_r  = t.is_w ? 0 : t.d2;
        cfg_resp   = t.resp;
        cfg_rdata  = t.rdata;
        exp_addr   = t.addr;
        exp_wdata  = t.wdata;
        exp_wstrb  = t.is_w ? t.wstrb : 4'd0;
        exp_arprot = t.instr ? 3'b100 : 3'b000;
        clear_stats();
        mem_valid_i = 1'b1;
        mem_instr_i = t.instr;
        mem_addr_i  = t.addr;
        mem_wdata_i = t.wdata;
        mem_wstrb_i = t.is_w ? t.wstrb : 4'd0;
        for (int n = 0; n < x.lat + 3; n++) begin
            cycle();
            if ((t.drop_early && cyc == 1) || ready_cnt != 0) mem_valid_i = 1'b0;
        end
        mem_valid_i = 1'b0;
        check($sformatf("%s latency", tag), 64'(ready_at), 64'(x.lat));
        check($sformatf("%s ready pulses", tag), 64'(ready_cnt), 64'd1);
        check($sformatf("%s bus_err pulses", tag), 64'(err_cnt), 64'(x.err));
        if (x.err != 0) check($sformatf("%s bus_err cycle", tag), 64'(err_at), 64'(x.lat));
        check($sformatf("%s payload glitches", tag), 64'(payload_bad), 64'd0);
        if (!t.is_w) begin
            check($sformatf("%s rdata", tag), 64'(rdata_seen), 64'(x.rdata));
            check($sformatf("%s arvalid cycles", tag), 64'(ar_cnt), 64'(x.ar_hi));
            check($sformatf("%s rready cycles", tag), 64'(r_cnt), 64'(x.r_hi));
            check($sformatf("%s ar/r handshakes", tag), 64'({ar_hs, r_hs}), 64'({x.ar_hs, x.r_hs}));
        end else begin
            check($sformatf("%s awvalid cycles", tag), 64'(aw_cnt), 64'(x.aw_hi));
            check($sformatf("%s wvalid cycles", tag), 64'(w_cnt), 64'(x.w_hi));
            check($sformatf("%s bready cycles", tag), 64'(b_cnt), 64'(x.b_hi));
            check($sformatf("%s aw/w/b handshakes", tag), {16'd0, 16'(aw_hs), 16'(w_hs), 16'(b_hs)},
                  {16'd0, 16'(x.aw_hs), 16'(x.w_hs), 16'(x.b_hs)});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s ctrl", tag),
              64'({mem_ready_o, m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, bus_err_o}), 64'd0);
        check($sformatf("%s rdata", tag), 64'(mem_rdata_o), 64'd0);
        check($sformatf("%s addr", tag), {m_awaddr_o, m_araddr_o}, 64'd0);
        check($sformatf("%s wdata/strb/prot", tag), 64'({m_wdata_o, m_wstrb_o, m_awprot_o, m_arprot_o}), 64'd0);
    endtask

    function automatic int pick_delay();
        return ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(0, 4));
    endfunction

    initial begin
        //           is_w instr addr          wdata          wstrb    d1    d2    d3  resp   rdata          drop lat  err rdata_exp
        tbl[0]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         4'b0000, 0,    0,    0,  2'b00, 32'hDEADBEEF, 1'b0, 3,   1'b0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_2004, 32'h12345678,  4'b0011, 0,    1,    0,  2'b00, 32'h0,        1'b0, 4,   1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_3000, 32'h0,         4'b0000, 0,    0,    0,  2'b10, 32'hCAFEF00D, 1'b0, 3,   1'b1, 32'hCAFEF00D};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,         4'b0000, 1000, 0,    0,  2'b00, 32'h11111111, 1'b0, 256, 1'b1, 32'hFFFFFFFF};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_2008, 32'hA5A5A5A5,  4'b1100, 2,    0,    3,  2'b11, 32'h0,        1'b0, 8,   1'b1, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0000_100C, 32'h0,         4'b0000, 254,  0,    0,  2'b00, 32'h55AA55AA, 1'b0, 257, 1'b0, 32'h55AA55AA};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_2010, 32'h0F0F0F0F,  4'b1111, 1,    1,    1000, 2'b00, 32'h0,      1'b0, 258, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0000_1010, 32'h0,         4'b0000, 2,    4,    0,  2'b00, 32'h0BADF00D, 1'b1, 9,   1'b0, 32'h0BADF00D};
        tbl[8]  = '{1'b1, 1'b0, 32'h0000_2014, 32'h87654321,  4'b0001, 3,    0,    0,  2'b00, 32'h0,        1'b0, 6,   1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_2018, 32'h00000001,  4'b0010, 0,    1000, 0,  2'b00, 32'h0,        1'b0, 256, 1'b1, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_1014, 32'h0,         4'b0000, 0,    1000, 0,  2'b00, 32'h77777777, 1'b0, 257, 1'b1, 32'hFFFFFFFF};

        resetn = 1'b0;
        mem_valid_i = 1'b0; mem_instr_i = 1'b0; mem_addr_i = 32'd0;
        mem_wdata_i = 32'd0; mem_wstrb_i = 4'd0;
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = 2'b00;
        m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = 32'd0; m_rresp_i = 2'b00;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
        cfg_resp = 2'b00; cfg_rdata = 32'd0;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_wstrb = 4'd0; exp_arprot = 3'b000;
        clear_stats();

        repeat (3) cycle();
        check_all_zero("reset");
        resetn = 1'b1;
        cycle();

        for (int i = 0; i < 11; i++) begin
            e = model(tbl[i]);
            e.lat   = tbl[i].lat;
            e.err   = tbl[i].err ? 1 : 0;
            e.rdata = tbl[i].rdata_exp;
            run_txn(tbl[i], e, $sformatf("vec%0d", i));
        end

        // Requester keeps valid high through DONE: the DONE cycle must not
        // launch anything, the following IDLE cycle starts a fresh read.
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
        cfg_resp = 2'b00; cfg_rdata = 32'h600DF00D;
        exp_addr = 32'h0000_4000; exp_arprot = 3'b000;
        clear_stats();
        mem_valid_i = 1'b1; mem_instr_i = 1'b0; mem_addr_i = 32'h0000_4000; mem_wstrb_i = 4'd0;
        repeat (3) cycle();
        check("hold first ready", 64'(mem_ready_o), 64'd1);
        cycle();
        check("hold nothing issued in DONE", 64'({m_arvalid_o, m_awvalid_o, mem_ready_o}), 64'd0);
        cycle();
        check("hold restart from IDLE", 64'(m_arvalid_o), 64'd1);
        mem_valid_i = 1'b0;
        repeat (2) cycle();
        check("hold second ready", 64'(mem_ready_o), 64'd1);
        check("hold second rdata", 64'(mem_rdata_o), 64'h600DF00D);
        repeat (2) cycle();
        check("hold ready pulses", 64'(ready_cnt), 64'd2);

        // Reset while waiting for the write response.
        cfg_aw = 0; cfg_w = 0; cfg_b = 100000;
        exp_addr = 32'h0000_5000; exp_wdata = 32'hFEEDFACE; exp_wstrb = 4'b1111;
        clear_stats();
        mem_valid_i = 1'b1; mem_addr_i = 32'h0000_5000; mem_wdata_i = 32'hFEEDFACE; mem_wstrb_i = 4'b1111;
        repeat (2) cycle();
        check("wresp bready before reset", 64'(m_bready_o), 64'd1);
        resetn = 1'b0;
        mem_valid_i = 1'b0;
        cycle();
        check_all_zero("reset in WRESP");
        resetn = 1'b1;
        repeat (4) cycle();
        check("no ready after reset", 64'(ready_cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            v.is_w       = ($urandom_range(0, 1) == 1);
            v.instr      = v.is_w ? 1'b0 : ($urandom_range(0, 1) == 1);
            v.addr       = $urandom & 32'hFFFF_FFFC;
            v.wdata      = $urandom;
            v.wstrb      = 4'($urandom_range(1, 15));
            v.d1         = pick_delay();
            v.d2         = pick_delay();
            v.d3         = pick_delay();
            v.resp       = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.rdata      = $urandom;
            v.drop_early = ($urandom_range(0, 1) == 1);
            v.lat = 0; v.err = 1'b0; v.rdata_exp = 32'd0;
            e = model(v);
            run_txn(v, e, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
